ah_cam_wr_initiator: RTL

AH_CAM_WR_INITIATOR -- requirements
Module: ah_cam_wr_initiator

---
 rtl/ah_cam_wr_if.sv | 26 ++
 rtl/ah_cam_wr_initiator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ah_cam_wr_if.sv
// Upstream request, CAM write and credit-return signals of the CAM write initiator.
// master is the initiator side; slave is the side that feeds it and owns the CAM.
interface ah_cam_wr_if #(
    parameter int DATAW = 128,
    parameter int CNTW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             wvalid;
    logic [DATAW-1:0] wdata;
    logic             wcredit;
    logic [CNTW:0]    credits;
    logic [15:0]      stall_cnt;
    logic             cred_err;

    modport master (
        input  in_valid, in_data, wcredit,
        output in_ready, wvalid, wdata, credits, stall_cnt, cred_err
    );

    modport slave (
        output in_valid, in_data, wcredit,
        input  in_ready, wvalid, wdata, credits, stall_cnt, cred_err
    );
endinterface

// File: rtl/ah_cam_wr_initiator.sv
// Credit-based CAM write initiator: a 2-entry input FIFO drains into single-cycle
// CAM write strobes, one per available credit, with stall and overflow reporting.
//
// state  | meaning
// INIT   | after reset: load credits, accept nothing
// RUN    | credits available, buffered entries are issued
// NOCRED | credit count is zero, entries wait in the buffer
module ah_cam_wr_initiator #(
    parameter int CAMDEPTH = 20,
    parameter int DATAW    = 128,
    parameter int CNTW     = 5
) (
    input  logic        clk,
    input  logic        rst_an,
    ah_cam_wr_if.master bus
);
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        NOCRED = 2'd2
    } state_t;

    localparam logic [CNTW:0] DEPTH_C = (CNTW+1)'(CAMDEPTH);

    state_t           state_q, state_d;
    logic [CNTW:0]    credits_q, credits_d;
    logic             cred_err_q, cred_err_d;
    logic [15:0]      stall_q, stall_d;
    logic             wvalid_q, wvalid_d;
    logic [DATAW-1:0] wdata_q, wdata_d;
    logic [DATAW-1:0] mem0_q, mem0_d;
    logic [DATAW-1:0] mem1_q, mem1_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;

    logic             in_ready;
    logic             push;
    logic             issue;
    logic             credit_ret;
    logic             overflow;
    logic [DATAW-1:0] head;

    // Issue only spends credits already registered; a same-cycle return lands next cycle.
    assign in_ready   = (state_q != INIT) && (occ_q != 2'd2);
    assign push       = bus.in_valid && in_ready;
    assign issue      = (state_q != INIT) && (occ_q != 2'd0) && (credits_q != '0);
    assign credit_ret = bus.wcredit && (state_q != INIT);
    assign overflow   = credit_ret && !issue && (credits_q == DEPTH_C);
    assign head       = rd_ptr_q ? mem1_q : mem0_q;

    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        cred_err_d = cred_err_q;
        case (state_q)
            INIT: begin
                credits_d = DEPTH_C;
                state_d   = RUN;
            end
            RUN, NOCRED: begin
                if (overflow) begin
                    cred_err_d = 1'b1;
                end else begin
                    credits_d = credits_q - (CNTW+1)'(issue) + (CNTW+1)'(credit_ret);
                end
                state_d = (credits_d == '0) ? NOCRED : RUN;
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ issue;
        occ_d    = occ_q + {1'b0, push} - {1'b0, issue};
        if (push && !wr_ptr_q) mem0_d = bus.in_data;
        if (push &&  wr_ptr_q) mem1_d = bus.in_data;

        wvalid_d = issue;
        wdata_d  = issue ? head : wdata_q;

        stall_d = stall_q;
        if ((occ_q != 2'd0) && (credits_q == '0) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= INIT;
            credits_q  <= '0;
            cred_err_q <= 1'b0;
            stall_q    <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            mem0_q     <= '0;
            mem1_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            cred_err_q <= cred_err_d;
            stall_q    <= stall_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.credits   = credits_q;
    assign bus.stall_cnt = stall_q;
    assign bus.cred_err  = cred_err_q;
endmodule
